// File: rtl/i_cache_assoc_pf_pkg.sv
// Shared types and tree-PLRU helpers for the set-associative instruction cache.
package i_cache_types;

   // Address split for the default geometry (256-bit lines, 8 sets, 32-bit addresses)
   localparam int unsigned s_offset = 5;
   localparam int unsigned s_index  = 3;
   localparam int unsigned s_tag    = 32 - s_offset - s_index;

   typedef logic [s_tag-1:0] tag_t;

   typedef enum logic [1:0] {IDLE, FILL, PF_FILL} ic_state_e;

   // Walk the tree from the root; each bit names the subtree holding the victim (0 = left).
   // Bits are heap-ordered (node n at bit n-1), padded to the 8-way maximum.
   function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int unsigned levels);
      int unsigned node;
      node = 1;
      for (int unsigned l = 0; l < 3; l++) begin
         if (l < levels) node = (node << 1) | 32'(bits[3'(node - 1)]);
      end
      return 3'(node - (32'd1 << levels));
   endfunction

   // Point every node on the path to the used way towards the other subtree.
   function automatic logic [6:0] plru_update(input logic [6:0] bits, input logic [2:0] way,
                                              input int unsigned levels);
      logic [6:0]  r;
      logic        dir;
      int unsigned node;
      r    = bits;
      node = 1;
      for (int unsigned l = 0; l < 3; l++) begin
         if (l < levels) begin
            dir               = way[2'(levels - 1 - l)];
            r[3'(node - 1)]   = ~dir;
            node              = (node << 1) | 32'(dir);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/i_cache_assoc_pf_plru.sv
// Per-set tree-PLRU state with a combinational victim read and a single update port.
module i_cache_plru_array
   import i_cache_types::*;
#(
   parameter int unsigned NUM_WAYS = 4,
   parameter int unsigned NUM_SETS = 8,
   parameter int unsigned IDX_W    = $clog2(NUM_SETS),
   parameter int unsigned WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_index,
   output logic [WAY_W-1:0] victim_c,
   input  logic             upd,
   input  logic [IDX_W-1:0] upd_index,
   input  logic [WAY_W-1:0] upd_way
);

   localparam int unsigned LEVELS = $clog2(NUM_WAYS);
   // A single way keeps one dummy bit that the update never changes.
   localparam int unsigned PW     = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

   logic [PW-1:0] plru_q [NUM_SETS];

   assign victim_c = WAY_W'(plru_victim(7'(plru_q[rd_index]), LEVELS));

   // Clear all trees on reset, otherwise fold one access into the addressed set.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < int'(NUM_SETS); s++) plru_q[IDX_W'(s)] <= '0;
      end else if (upd) begin
         plru_q[upd_index] <= PW'(plru_update(7'(plru_q[upd_index]), 3'(upd_way), LEVELS));
      end
   end

endmodule

// File: rtl/i_cache_assoc_pf.sv
// N-way set-associative read-only instruction cache with next-line prefetch and flush.
module i_cache_assoc_pf
   import i_cache_types::*;
#(
   parameter int unsigned NUM_WAYS = 4,
   parameter int unsigned NUM_SETS = 8,
   parameter int unsigned LINE_W   = 256,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned PF_EN    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic [31:0]       mem_address,
   input  logic              flush,
   output logic              mem_resp,
   output logic [OUT_W-1:0]  mem_rdata,
   output logic [31:0]       pmem_address,
   output logic              pmem_read,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int unsigned OFF_W      = $clog2(LINE_W / 8);
   localparam int unsigned IDX_W      = $clog2(NUM_SETS);
   localparam int unsigned TAG_W      = 32 - OFF_W - IDX_W;
   localparam int unsigned BYTE_W     = $clog2(OUT_W / 8);
   localparam int unsigned WORD_W     = OFF_W - BYTE_W;
   localparam int unsigned WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int unsigned LINE_BYTES = LINE_W / 8;

   ic_state_e           state;
   logic [31:0]         fill_line;
   logic [31:0]         pf_line;
   logic                pf_pending;
   logic                flush_pend;

   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
   logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];

   logic [TAG_W-1:0]    req_tag, fill_tag, pf_tag;
   logic [IDX_W-1:0]    req_idx, fill_idx, pf_idx;
   logic [WORD_W-1:0]   req_word;
   logic                hit, pf_present, hit_c, fill_done, kill;
   logic [WAY_W-1:0]    hit_way, victim, plru_victim_c;
   logic [LINE_W-1:0]   hit_line;
   logic                unused_addr;

   assign req_tag     = mem_address[31 -: TAG_W];
   assign req_idx     = mem_address[OFF_W +: IDX_W];
   assign req_word    = mem_address[BYTE_W +: WORD_W];
   assign fill_tag    = fill_line[31 -: TAG_W];
   assign fill_idx    = fill_line[OFF_W +: IDX_W];
   assign pf_tag      = pf_line[31 -: TAG_W];
   assign pf_idx      = pf_line[OFF_W +: IDX_W];
   assign unused_addr = ^mem_address[BYTE_W-1:0];

   // Tag compare for the demand request and for the pending prefetch line.
   always_comb begin
      hit        = 1'b0;
      hit_way    = '0;
      pf_present = 1'b0;
      for (int w = 0; w < int'(NUM_WAYS); w++) begin
         if (valid_q[req_idx][WAY_W'(w)] && tag_q[req_idx][WAY_W'(w)] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (valid_q[pf_idx][WAY_W'(w)] && tag_q[pf_idx][WAY_W'(w)] == pf_tag) pf_present = 1'b1;
      end
   end

   // Fill victim: lowest invalid way of the fill set, else the PLRU choice.
   always_comb begin
      victim = plru_victim_c;
      for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
         if (!valid_q[fill_idx][WAY_W'(w)]) victim = WAY_W'(w);
      end
   end

   assign hit_c        = mem_read && hit && (state == IDLE) && !rst;
   assign fill_done    = (state != IDLE) && pmem_resp;
   assign kill         = flush || flush_pend;
   assign hit_line     = data_q[req_idx][hit_way];
   assign mem_resp     = hit_c;
   assign mem_rdata    = hit_c ? OUT_W'(hit_line >> (OUT_W * 32'(req_word))) : '0;
   assign pmem_read    = (state != IDLE);
   assign pmem_address = fill_line;

   i_cache_plru_array #(
      .NUM_WAYS (NUM_WAYS),
      .NUM_SETS (NUM_SETS),
      .IDX_W    (IDX_W),
      .WAY_W    (WAY_W)
   ) u_plru (
      .clk       (clk),
      .rst       (rst),
      .rd_index  (fill_idx),
      .victim_c  (plru_victim_c),
      .upd       (hit_c || fill_done),
      .upd_index (hit_c ? req_idx : fill_idx),
      .upd_way   (hit_c ? hit_way : victim)
   );

   // Controller: demand fills, prefetch launch/drop, flush handling and valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         fill_line  <= '0;
         pf_line    <= '0;
         pf_pending <= 1'b0;
         flush_pend <= 1'b0;
         for (int s = 0; s < int'(NUM_SETS); s++) valid_q[IDX_W'(s)] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  for (int s = 0; s < int'(NUM_SETS); s++) valid_q[IDX_W'(s)] <= '0;
                  pf_pending <= 1'b0;
               end
               if (mem_read && !hit) begin
                  state      <= FILL;
                  fill_line  <= mem_address & ~32'(LINE_BYTES - 1);
                  pf_pending <= 1'b0;
               end else if (!mem_read && pf_pending && !flush) begin
                  pf_pending <= 1'b0;
                  if (!pf_present) begin
                     state     <= PF_FILL;
                     fill_line <= pf_line;
                  end
               end
            end
            FILL, PF_FILL: begin
               if (flush) flush_pend <= 1'b1;
               if (pmem_resp) begin
                  state      <= IDLE;
                  flush_pend <= 1'b0;
                  if (kill) begin
                     for (int s = 0; s < int'(NUM_SETS); s++) valid_q[IDX_W'(s)] <= '0;
                  end else begin
                     valid_q[fill_idx][victim] <= 1'b1;
                  end
                  if (state == FILL && PF_EN != 0 && !kill) begin
                     pf_pending <= 1'b1;
                     pf_line    <= fill_line + 32'(LINE_BYTES);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line and tag storage, written only when a fill completes.
   always_ff @(posedge clk) begin
      if (!rst && fill_done) begin
         data_q[fill_idx][victim] <= pmem_rdata;
         tag_q[fill_idx][victim]  <= fill_tag;
      end
   end

endmodule

// File: tb/tb_i_cache_assoc_pf.sv
// Directed bench for i_cache_assoc_pf with a fixed-latency line memory model.
module tb_i_cache_assoc_pf;

   localparam int LAT = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         mem_read = 1'b0;
   logic [31:0]  mem_address = '0;
   logic         flush = 1'b0;
   logic         mem_resp;
   logic [31:0]  mem_rdata;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           cnt;
   int           fill_cnt = 0;
   int           addr_changed = 0;
   logic [31:0]  last_addr;
   logic         stray_req = 1'b0;

   i_cache_assoc_pf #(
      .NUM_WAYS (4),
      .NUM_SETS (8),
      .LINE_W   (256),
      .OUT_W    (32),
      .PF_EN    (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .flush        (flush),
      .mem_resp     (mem_resp),
      .mem_rdata    (mem_rdata),
      .pmem_address (pmem_address),
      .pmem_read    (pmem_read),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   // Memory contents: every word holds its own word address xor a marker.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [255:0] line_data(input logic [31:0] la);
      logic [255:0] d;
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = word_of(la + 32'(4 * j));
      return d;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Line memory: answers each fill on its LAT-th cycle of pmem_read.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      cnt        = 0;
      forever begin
         @(negedge clk);
         pmem_resp = 1'b0;
         if (rst) begin
            cnt = 0;
         end else if (stray_req) begin
            pmem_resp  = 1'b1;
            pmem_rdata = line_data(32'h100);
         end else if (pmem_read) begin
            if (cnt == 0) begin
               fill_cnt++;
               last_addr = pmem_address;
            end else if (pmem_address != last_addr) begin
               addr_changed++;
            end
            cnt++;
            if (cnt == LAT) begin
               pmem_resp  = 1'b1;
               pmem_rdata = line_data(pmem_address);
               cnt        = 0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      mem_read = 1'b0;
      flush    = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Hold a read until mem_resp; lat counts the cycles before the response.
   task automatic do_read(input logic [31:0] a, input int flush_at, output int lat,
                          output logic [31:0] data, output int pr_at, output logic [31:0] pr_addr);
      logic got;
      got     = 1'b0;
      lat     = -1;
      data    = '0;
      pr_at   = -1;
      pr_addr = '0;
      mem_read    = 1'b1;
      mem_address = a;
      for (int cyc = 0; cyc < 60 && !got; cyc++) begin
         flush = (cyc == flush_at);
         @(negedge clk);
         if (pmem_read && pr_at < 0) begin
            pr_at   = cyc;
            pr_addr = pmem_address;
         end
         if (mem_resp) begin
            got  = 1'b1;
            lat  = cyc;
            data = mem_rdata;
         end
         tick();
      end
      flush    = 1'b0;
      mem_read = 1'b0;
      if (!got) check_eq("read_completed", 32'(got), 32'd1);
   endtask

   task automatic wait_launch(input logic [31:0] a, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (pmem_read && pmem_address == a) seen = 1'b1;
         tick();
      end
   endtask

   task automatic wait_idle(output logic idle);
      idle = 1'b0;
      for (int i = 0; i < 30 && !idle; i++) begin
         @(negedge clk);
         if (!pmem_read) idle = 1'b1;
         tick();
      end
   endtask

   int          lat, pr_at, f0;
   logic [31:0] data, pr_addr;
   logic        seen, idle;

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      check_eq("rst_mem_resp", 32'(mem_resp), 32'd0);
      check_eq("rst_mem_rdata", mem_rdata, 32'd0);
      check_eq("rst_pmem_read", 32'(pmem_read), 32'd0);
      check_eq("rst_pmem_address", pmem_address, 32'd0);
      tick();

      // 1: cold miss
      do_read(32'h100, -1, lat, data, pr_at, pr_addr);
      check_eq("t1_pmem_read_cycle", 32'(pr_at), 32'd1);
      check_eq("t1_pmem_address", pr_addr, 32'h100);
      check_eq("t1_latency", 32'(lat), 32'(LAT + 1));
      check_eq("t1_rdata", data, 32'hC0DE_0100);

      // 2: next-line prefetch without a request, then a 0-wait hit
      wait_launch(32'h120, seen);
      check_eq("t2_pf_launch", 32'(seen), 32'd1);
      wait_idle(idle);
      check_eq("t2_pf_done", 32'(idle), 32'd1);
      do_read(32'h124, -1, lat, data, pr_at, pr_addr);
      check_eq("t2_hit_latency", 32'(lat), 32'd0);
      check_eq("t2_rdata", data, 32'hC0DE_0124);

      // 3: five lines into set 0; PLRU evicts 0x000
      do_reset();
      for (int k = 0; k < 5; k++) begin
         do_read(32'(k) << 8, -1, lat, data, pr_at, pr_addr);
         check_eq("t3_fill_miss", 32'(lat > 0), 32'd1);
      end
      check_eq("t3_rdata_0x400", data, 32'hC0DE_0400);
      do_read(32'h000, -1, lat, data, pr_at, pr_addr);
      check_eq("t3_evicted_0x000_misses", 32'(lat > 0), 32'd1);
      do_read(32'h104, -1, lat, data, pr_at, pr_addr);
      check_eq("t3_0x100_hits", 32'(lat), 32'd0);
      check_eq("t3_rdata_0x104", data, 32'hC0DE_0104);
      do_read(32'h31C, -1, lat, data, pr_at, pr_addr);
      check_eq("t3_0x300_hits", 32'(lat), 32'd0);
      check_eq("t3_rdata_0x31c", data, 32'hC0DE_031C);
      do_read(32'h200, -1, lat, data, pr_at, pr_addr);
      check_eq("t3_0x200_evicted", 32'(lat > 0), 32'd1);

      // 4: demand during PF_FILL, first to the prefetched line, then to another line
      do_reset();
      do_read(32'h200, -1, lat, data, pr_at, pr_addr);
      wait_launch(32'h220, seen);
      check_eq("t4_pf_launch_a", 32'(seen), 32'd1);
      do_read(32'h224, -1, lat, data, pr_at, pr_addr);
      check_eq("t4_stall_then_hit", 32'(lat), 32'(LAT - 1));
      check_eq("t4_rdata_0x224", data, 32'hC0DE_0224);
      wait_idle(idle);
      do_read(32'h600, -1, lat, data, pr_at, pr_addr);
      wait_launch(32'h620, seen);
      check_eq("t4_pf_launch_b", 32'(seen), 32'd1);
      do_read(32'h708, -1, lat, data, pr_at, pr_addr);
      check_eq("t4_stall_then_refill", 32'(lat), 32'(LAT - 1 + LAT + 1));
      check_eq("t4_rdata_0x708", data, 32'hC0DE_0708);
      check_eq("t4_pmem_address_stable", 32'(addr_changed), 32'd0);

      // 5: flush in IDLE with a hit, then flush in the middle of a fill
      do_reset();
      do_read(32'h100, -1, lat, data, pr_at, pr_addr);
      wait_launch(32'h120, seen);
      wait_idle(idle);
      do_read(32'h124, 0, lat, data, pr_at, pr_addr);
      check_eq("t5_hit_with_flush", 32'(lat), 32'd0);
      check_eq("t5_rdata_pre_flush", data, 32'hC0DE_0124);
      do_read(32'h128, -1, lat, data, pr_at, pr_addr);
      check_eq("t5_flushed_line_misses", 32'(lat), 32'(LAT + 1));
      f0 = fill_cnt;
      do_read(32'h300, 2, lat, data, pr_at, pr_addr);
      check_eq("t5_flush_mid_fill_latency", 32'(lat), 32'(2 * (LAT + 1)));
      check_eq("t5_fill_count", 32'(fill_cnt - f0), 32'd2);
      check_eq("t5_rdata_0x300", data, 32'hC0DE_0300);
      do_read(32'h128, -1, lat, data, pr_at, pr_addr);
      check_eq("t5_prior_line_misses", 32'(lat), 32'(LAT + 1));

      // 6: reset during a fill, then a stray pmem_resp
      do_reset();
      mem_read    = 1'b1;
      mem_address = 32'h100;
      tick();
      tick();
      tick();
      @(negedge clk);
      check_eq("t6_in_fill", 32'(pmem_read), 32'd1);
      tick();
      rst      = 1'b1;
      mem_read = 1'b0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("t6_pmem_read_after_rst", 32'(pmem_read), 32'd0);
      check_eq("t6_pmem_address_after_rst", pmem_address, 32'd0);
      tick();
      stray_req = 1'b1;
      @(negedge clk);
      check_eq("t6_no_resp_on_stray", 32'(mem_resp), 32'd0);
      tick();
      stray_req = 1'b0;
      @(negedge clk);
      check_eq("t6_no_fill_after_stray", 32'(pmem_read), 32'd0);
      tick();
      do_read(32'h100, -1, lat, data, pr_at, pr_addr);
      check_eq("t6_0x100_misses", 32'(lat), 32'(LAT + 1));
      check_eq("t6_rdata", data, 32'hC0DE_0100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
